// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between the producer/consumer side and the stream_mux_rr mux.
// The master side drives the inputs and the consumer ready. The slave side is the mux.
interface stream_mux_rr_if #(
  parameter int CH_NUM = 5,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) ();
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [CH_NUM*DATA_W-1:0] in_data;
  logic [CH_NUM-1:0]        in_valid;
  logic [CH_NUM-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [SEL_W-1:0]         out_ch;
  logic                     sel_err;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch, sel_err
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch, sel_err
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed-select or round-robin grant and a registered output.
// Define STREAM_MUX_STICKY_ERR_EN to make sel_err a sticky register that only reset clears.
module stream_mux_rr #(
  parameter int CH_NUM = 5,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_mux_rr_if.slave bus
);
  logic [DATA_W-1:0] chan_data [CH_NUM];
  logic [CH_NUM-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  cand_idx;
  logic              any_grant;
  logic              load;
  logic              sel_ok;

  logic [SEL_W-1:0]  ptr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [SEL_W-1:0]  ch_reg;
  logic              valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_chan
      assign chan_data[gi]    = bus.in_data[gi*DATA_W +: DATA_W];
      assign bus.in_ready[gi] = grant[gi] & load;
    end
  endgenerate

  assign sel_ok    = ({1'b0, bus.sel} < (SEL_W+1)'(CH_NUM));
  assign load      = ~valid_reg | bus.out_ready;
  assign any_grant = |grant;

  // Round-robin scans farthest-first so the nearest valid channel after ptr wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand_idx  = '0;
    if (!bus.mode) begin
      if (sel_ok && bus.in_valid[bus.sel]) begin
        grant[bus.sel] = 1'b1;
        grant_idx      = bus.sel;
      end
    end else begin
      for (int k = CH_NUM; k >= 1; k--) begin
        cand_idx = SEL_W'((int'(ptr_reg) + k) % CH_NUM);
        if (bus.in_valid[cand_idx]) begin
          grant           = '0;
          grant[cand_idx] = 1'b1;
          grant_idx       = cand_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ch_reg    <= '0;
      ptr_reg   <= SEL_W'(CH_NUM - 1);
    end else if (load) begin
      if (any_grant) begin
        valid_reg <= 1'b1;
        data_reg  <= chan_data[grant_idx];
        ch_reg    <= grant_idx;
        if (bus.mode) begin
          ptr_reg <= grant_idx;
        end
      end else begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_reg;
  assign bus.out_data  = data_reg;
  assign bus.out_ch    = ch_reg;

`ifdef STREAM_MUX_STICKY_ERR_EN
  logic err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (!bus.mode && !sel_ok) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.sel_err = err_reg;
`else
  assign bus.sel_err = ~bus.mode & ~sel_ok;
`endif
endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomised scoreboard bench for stream_mux_rr: the driver predicts beats from a channel-queue
// model of the mux rules, and an independent monitor checks every beat the DUT presents.
module tb_stream_mux_rr;
  localparam int CH_NUM = 5;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                ch;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  stream_mux_rr #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] pend_data [CH_NUM];
  bit                pend_vld  [CH_NUM];
  int                m_last;
  bit                m_busy;
  bit                m_sticky;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One clock cycle of stimulus; the model decides which channel the rules grant.
  task automatic step(input bit mode, input int sel, input bit ordy, input int new_pct);
    int                g;
    bit                load;
    bit                exp_err;
    logic [CH_NUM-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < CH_NUM; i++) begin
      if (!pend_vld[i] && $urandom_range(99) < new_pct) begin
        pend_vld[i]  = 1'b1;
        pend_data[i] = DATA_W'($urandom);
      end
      bus.in_valid[i]                 = pend_vld[i];
      bus.in_data[i*DATA_W +: DATA_W] = pend_data[i];
    end
    rst_n         = 1'b1;
    bus.mode      = mode;
    bus.sel       = SEL_W'(sel);
    bus.out_ready = ordy;

    g = -1;
    if (!mode) begin
      if (sel < CH_NUM && pend_vld[sel]) g = sel;
    end else begin
      for (int k = 1; k <= CH_NUM; k++) begin
        int c;
        c = (m_last + k) % CH_NUM;
        if (g < 0 && pend_vld[c]) g = c;
      end
    end
    load    = !m_busy || ordy;
    exp_rdy = '0;
    if (load && g >= 0) exp_rdy[g] = 1'b1;
`ifdef STREAM_MUX_STICKY_ERR_EN
    exp_err = m_sticky;
`else
    exp_err = !mode && sel >= CH_NUM;
`endif
    #1;
    check("in_ready", int'(bus.in_ready), int'(exp_rdy));
    check("sel_err", int'(bus.sel_err), int'(exp_err));

    if (load) begin
      if (g >= 0) begin
        exp_q.push_back('{pend_data[g], g});
        pend_vld[g] = 1'b0;
        m_busy      = 1'b1;
        if (mode) m_last = g;
      end else begin
        m_busy = 1'b0;
      end
    end
    if (!mode && sel >= CH_NUM) m_sticky = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.mode      = 1'b1;
    bus.out_ready = 1'b1;
    m_last        = CH_NUM - 1;
    m_busy        = 1'b0;
    m_sticky      = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #2;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_ch", int'(bus.out_ch), 0);
    check("rst_sel_err", int'(bus.sel_err), 0);
  endtask

  // Monitor: a beat is new when the previous cycle could load; otherwise it must hold.
  initial begin
    bit    fresh;
    beat_t last;
    beat_t e;
    fresh = 1'b1;
    last  = '{'0, 0};
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && bus.out_valid) begin
        if (fresh) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got ch=%0d data=0x%02h, required no beat",
                     bus.out_ch, bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", int'(bus.out_data), int'(e.data));
            check("out_ch", int'(bus.out_ch), e.ch);
            $display("[TB] beat ch=%0d data=0x%02h", bus.out_ch, bus.out_data);
          end
          last = '{bus.out_data, int'(bus.out_ch)};
        end else begin
          check("hold_data", int'(bus.out_data), int'(last.data));
          check("hold_ch", int'(bus.out_ch), last.ch);
        end
      end
      @(negedge clk);
      #2;
      fresh = !bus.out_valid || bus.out_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish within 200000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      pend_vld[i]  = 1'b0;
      pend_data[i] = '0;
    end
    do_reset();

    // Fixed select of ch3 with every channel valid.
    for (int i = 0; i < CH_NUM; i++) begin
      pend_vld[i]  = 1'b1;
      pend_data[i] = DATA_W'(8'h10 + i);
    end
    pend_data[3] = 8'hA5;
    step(1'b0, 3, 1'b1, 0);
    step(1'b0, 3, 1'b1, 0);

    // Round-robin with all channels valid continuously.
    for (int n = 0; n < 12; n++) step(1'b1, 0, 1'b1, 100);

    // Park ptr on ch1, then only ch1 and ch4 active.
    for (int i = 0; i < CH_NUM; i++) pend_vld[i] = 1'b0;
    step(1'b1, 0, 1'b1, 0);
    pend_vld[1] = 1'b1;
    step(1'b1, 0, 1'b1, 0);
    for (int n = 0; n < 3; n++) begin
      pend_vld[1] = 1'b1;
      pend_vld[4] = 1'b1;
      step(1'b1, 0, 1'b1, 0);
    end

    // Back-pressure for three cycles, then release with a same-cycle reload.
    step(1'b1, 0, 1'b1, 100);
    for (int n = 0; n < 3; n++) step(1'b1, 0, 1'b0, 100);
    for (int n = 0; n < 2; n++) step(1'b1, 0, 1'b1, 100);

    // Out-of-range select, then back to a valid one.
    for (int n = 0; n < 2; n++) step(1'b0, 6, 1'b1, 100);
    for (int n = 0; n < 2; n++) step(1'b0, 2, 1'b1, 100);

    // Reset mid-stream in round-robin mode; ch0 must win first afterwards.
    for (int n = 0; n < 3; n++) step(1'b1, 0, 1'b1, 100);
    do_reset();
    for (int n = 0; n < 3; n++) step(1'b1, 0, 1'b1, 100);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(3) != 0), int'($urandom_range(7)),
           bit'($urandom_range(9) < 7), 50);
    end

    // Drain and confirm every predicted beat appeared.
    for (int n = 0; n < 8; n++) step(1'b1, 0, 1'b1, 0);
    @(posedge clk);
    #3;
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes and a registered output stage. It selects one input channel either by an explicit select value or by round-robin arbitration. It generalises the team's combinational 5:1 bit mux for datapaths that need back-pressure, fairness and out-of-range detection. It sits between multiple producer streams and a single downstream consumer.

## Interface
- CH_NUM, 5, number of input channels (2..16)
- DATA_W, 8, data width per channel
- SEL_W, 3, select/channel-index width; must satisfy 2**SEL_W >= CH_NUM
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- mode  input  1  0 = fixed select via `sel`, 1 = round-robin
- sel  input  SEL_W  channel index used when mode = 0
- in_data  input  CH_NUM*DATA_W  packed input data; channel i occupies bits [i*DATA_W +: DATA_W]
- in_valid  input  CH_NUM  per-channel valid
- in_ready  output  CH_NUM  per-channel ready (combinational)
- out_data  output  DATA_W  registered output data
- out_valid  output  1  registered output valid
- out_ready  input  1  downstream ready
- out_ch  output  SEL_W  index of the channel that produced out_data
- sel_err  output  1  fixed-mode select out of range (sel >= CH_NUM)

## Operation
- Output stage: one register (out_data, out_ch, out_valid). `load = ~out_valid | out_ready`.
- Grant, one-hot over CH_NUM, combinational:
  - mode 0: grant[sel] = in_valid[sel] if sel < CH_NUM, else no grant.
  - mode 1: first i with in_valid[i], searched from (ptr+1) mod CH_NUM upward with wrap.
- `in_ready[i] = grant[i] & load`. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On transfer: out_data <= channel data, out_ch <= i, out_valid <= 1. In mode 1, ptr <= i.
- When load is high and there is no transfer, out_valid <= 0.
- When load is low, the output register holds all of its contents.
- ptr is updated only on mode-1 transfers. It does not change in mode 0 and does not change when a mode switch occurs.
- A mode or sel change takes effect at the next grant evaluation. A transfer already in the output register is unaffected.
- Non-granted channels see in_ready = 0 and must hold their data (standard valid/ready rules).
- sel_err is combinational from sel when mode = 0, and 0 when mode = 1 (base build; see Configuration).

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_ch = 0.
  - ptr = CH_NUM-1, so channel 0 has first priority after reset.
  - sel_err = 0 in the sticky build.
- Latency: input accepted in cycle n appears on out_* in cycle n+1.
- Throughput: one transfer per cycle while out_ready = 1.
- out_ready low with out_valid high: all in_ready = 0, and out_* are stable until the beat is accepted.
- Simultaneous pop and push (out_valid & out_ready & new transfer): the new beat replaces the old one with no bubble.
- Round-robin wrap: with ptr = CH_NUM-1, the search order is 0,1,…,CH_NUM-1.
- Reset asserted mid-transfer: the in-flight beat is dropped, out_valid = 0 on the next edge, and ptr is reinitialised.

## Configuration
- `STREAM_MUX_STICKY_ERR_EN` defined:
  - sel_err is a register, set when mode = 0 and sel >= CH_NUM.
  - It is held until rst_n is asserted.
- Undefined: sel_err is combinational, `~mode & (sel >= CH_NUM)`, with no register.
- Datapath behaviour is identical in both builds.

## Test plan
- Mode 0, CH_NUM=5, sel=3, in_valid=5'b11111, ch3 data 0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=3; only in_ready[3] was high.
- Mode 1, all five channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,4,0,… with one beat per cycle.
- Mode 1, in_valid=5'b10010, ptr=1 -> grants ch4, then ch1, then ch4 (wrap and skip of idle channels).
- out_ready held 0 for 3 cycles with out_valid=1 -> out_data/out_ch stable and in_ready=0; on release, the next beat loads in the same cycle as the pop.
- Mode 0, sel=6 -> no transfer, out_valid falls to 0, sel_err=1. With the macro defined, sel_err stays 1 after sel returns to 2, until rst_n=0.
- rst_n=0 for one cycle mid-stream in mode 1 -> out_valid=0, out_data=0, out_ch=0; the first post-reset grant goes to ch0.
